// File: rtl/regfile_scoreboard.sv
// Two-write-port register file with same-cycle read bypass and a pending-bit scoreboard.
// Reads and stall are combinational; writes, issues and err take effect at the rising edge. No backpressure.
module regfile_scoreboard #(
    parameter int               DATA_W     = 16,
    parameter int               ADDR_W     = 4,
    parameter int               RESULT_IDX = 0,
    parameter int               ZERO_IDX   = 1,
    parameter int               SP_IDX     = 15,
    parameter logic [DATA_W-1:0] SP_INIT   = 16'hFFFE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rd_use_a,
    input  logic              rd_use_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              stall,
    output logic [ADDR_W:0]   pend_count,
    output logic              err,
    output logic [DATA_W-1:0] result_reg
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             pend_q, pend_d;
    logic                            err_q, err_d;
    logic                            iss_vld;
    logic                            iss_cleared;
    logic                            hazard_a, hazard_b;
    logic [ADDR_W:0]                 pend_cnt;

    // Bypass order: zero register first, then port B, then port A, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0]             addr,
        input logic                          a_en,
        input logic [ADDR_W-1:0]             a_addr,
        input logic [DATA_W-1:0]             a_data,
        input logic                          b_en,
        input logic [ADDR_W-1:0]             b_addr,
        input logic [DATA_W-1:0]             b_data,
        input logic [NUM_REGS-1:0][DATA_W-1:0] regs
    );
        logic [DATA_W-1:0] val;
        if (addr == ZERO_A) begin
            val = '0;
        end else if (b_en && b_addr == addr) begin
            val = b_data;
        end else if (a_en && a_addr == addr) begin
            val = a_data;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    function automatic logic written(input logic [ADDR_W-1:0] addr,
                                     input logic a_en, input logic [ADDR_W-1:0] a_addr,
                                     input logic b_en, input logic [ADDR_W-1:0] b_addr);
        return (a_en && a_addr == addr) || (b_en && b_addr == addr);
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, regs_q);
        rd_data_b = read_port(rd_addr_b, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, regs_q);
        hazard_a  = rd_use_a && pend_q[rd_addr_a] &&
                    !written(rd_addr_a, wa_en, wa_addr, wb_en, wb_addr);
        hazard_b  = rd_use_b && pend_q[rd_addr_b] &&
                    !written(rd_addr_b, wa_en, wa_addr, wb_en, wb_addr);
        stall     = hazard_a || hazard_b;
    end

    always_comb begin
        regs_d = regs_q;
        if (wa_en && wa_addr != ZERO_A) begin
            regs_d[wa_addr] = wa_data;
        end
        // Port B is applied last so it wins a same-address collision.
        if (wb_en && wb_addr != ZERO_A) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_comb begin
        iss_vld     = iss_en && iss_addr != ZERO_A;
        iss_cleared = written(iss_addr, wa_en, wa_addr, wb_en, wb_addr);
        pend_d      = pend_q;
        if (wa_en) begin
            pend_d[wa_addr] = 1'b0;
        end
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        // Set after clear: a new producer issued alongside the old writeback owns the register.
        if (iss_vld) begin
            pend_d[iss_addr] = 1'b1;
        end
        err_d = err_q || (iss_vld && pend_q[iss_addr] && !iss_cleared);
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_cnt = pend_cnt + {{ADDR_W{1'b0}}, pend_q[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX && i != ZERO_IDX) ? SP_INIT : '0;
            end
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pend_count = pend_cnt;
    assign err        = err_q;
    assign result_reg = (RESULT_IDX == ZERO_IDX) ? '0 : regs_q[RESULT_IDX];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, write priority, zero register, scoreboard, err and reset.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic        rd_use_a, rd_use_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        wa_en, wb_en, iss_en;
    logic [3:0]  wa_addr, wb_addr, iss_addr;
    logic [15:0] wa_data, wb_data;
    logic        stall, err;
    logic [4:0]  pend_count;
    logic [15:0] result_reg;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_use_a(rd_use_a), .rd_use_b(rd_use_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(stall), .pend_count(pend_count), .err(err), .result_reg(result_reg)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rd_use_a = 0; rd_use_b = 0;
        wa_en = 0; wb_en = 0; iss_en = 0;
        wa_addr = 0; wb_addr = 0; iss_addr = 0;
        wa_data = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle(); rd_addr_a = 0; rd_addr_b = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rd_addr_a = 4'd15; rd_addr_b = 4'd3; #1;
        checks++; if (rd_data_a !== 16'hFFFE) begin errors++; $display("FAIL reset_sp got=%h exp=fffe", rd_data_a); end
        checks++; if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL reset_r3 got=%h exp=0000", rd_data_b); end
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", pend_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (result_reg !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result_reg); end
    endtask

    task automatic test_bypass();
        wa_en = 1; wa_addr = 4'd3; wa_data = 16'h1234; rd_addr_a = 4'd3; #1;
        checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL bypass_a got=%h exp=1234", rd_data_a); end
        tick();
        rd_addr_a = 4'd3; #1;
        checks++; if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL stored_r3 got=%h exp=1234", rd_data_a); end
    endtask

    task automatic test_dual_write();
        wa_en = 1; wa_addr = 4'd5; wa_data = 16'hAAAA;
        wb_en = 1; wb_addr = 4'd5; wb_data = 16'h5555;
        rd_addr_a = 4'd5; rd_addr_b = 4'd5; #1;
        checks++; if (rd_data_a !== 16'h5555) begin errors++; $display("FAIL dual_bypass_a got=%h exp=5555", rd_data_a); end
        checks++; if (rd_data_b !== 16'h5555) begin errors++; $display("FAIL dual_bypass_b got=%h exp=5555", rd_data_b); end
        tick();
        rd_addr_b = 4'd5; #1;
        checks++; if (rd_data_b !== 16'h5555) begin errors++; $display("FAIL dual_stored got=%h exp=5555", rd_data_b); end
        // Distinct addresses on both ports in one cycle.
        wa_en = 1; wa_addr = 4'd6; wa_data = 16'h0606;
        wb_en = 1; wb_addr = 4'd8; wb_data = 16'h0808;
        rd_addr_a = 4'd6; rd_addr_b = 4'd8; #1;
        checks++; if (rd_data_a !== 16'h0606) begin errors++; $display("FAIL split_bypass_a got=%h exp=0606", rd_data_a); end
        checks++; if (rd_data_b !== 16'h0808) begin errors++; $display("FAIL split_bypass_b got=%h exp=0808", rd_data_b); end
        tick();
        rd_addr_a = 4'd6; rd_addr_b = 4'd8; #1;
        checks++; if (rd_data_a !== 16'h0606) begin errors++; $display("FAIL split_stored_a got=%h exp=0606", rd_data_a); end
        checks++; if (rd_data_b !== 16'h0808) begin errors++; $display("FAIL split_stored_b got=%h exp=0808", rd_data_b); end
    endtask

    task automatic test_zero();
        wa_en = 1; wa_addr = 4'd1; wa_data = 16'hFFFF;
        wb_en = 1; wb_addr = 4'd1; wb_data = 16'hFFFF;
        rd_addr_a = 4'd1; rd_addr_b = 4'd1; #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL zero_bypass got=%h exp=0000", rd_data_a); end
        tick();
        rd_addr_a = 4'd1; #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL zero_stored got=%h exp=0000", rd_data_a); end
        iss_en = 1; iss_addr = 4'd1; tick();
        iss_en = 1; iss_addr = 4'd1; tick();
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL zero_issue_pend got=%0d exp=0", pend_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_issue_err got=%b exp=0", err); end
    endtask

    task automatic test_result_reg();
        wa_en = 1; wa_addr = 4'd0; wa_data = 16'hBEEF; #1;
        checks++; if (result_reg !== 16'h0000) begin errors++; $display("FAIL result_no_bypass got=%h exp=0000", result_reg); end
        tick();
        checks++; if (result_reg !== 16'hBEEF) begin errors++; $display("FAIL result_stored got=%h exp=beef", result_reg); end
    endtask

    task automatic test_hazard();
        iss_en = 1; iss_addr = 4'd7; tick();
        rd_use_a = 1; rd_addr_a = 4'd7; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_stall got=%b exp=1", stall); end
        checks++; if (pend_count !== 5'd1) begin errors++; $display("FAIL hazard_pend got=%0d exp=1", pend_count); end
        rd_use_a = 0; rd_use_b = 1; rd_addr_b = 4'd7; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hazard_b_stall got=%b exp=1", stall); end
        rd_use_b = 0; rd_use_a = 1; rd_addr_a = 4'd7; rd_addr_b = 4'd7; #1;
        rd_use_a = 0; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_stall got=%b exp=0", stall); end
        rd_use_a = 1; wb_en = 1; wb_addr = 4'd7; wb_data = 16'h7777; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_stall got=%b exp=0", stall); end
        checks++; if (rd_data_a !== 16'h7777) begin errors++; $display("FAIL wb_bypass got=%h exp=7777", rd_data_a); end
        tick();
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL wb_pend got=%0d exp=0", pend_count); end
    endtask

    task automatic test_issue_wb_same();
        iss_en = 1; iss_addr = 4'd9; tick();
        iss_en = 1; iss_addr = 4'd9; wa_en = 1; wa_addr = 4'd9; wa_data = 16'h0009; tick();
        checks++; if (pend_count !== 5'd1) begin errors++; $display("FAIL iss_wb_pend got=%0d exp=1", pend_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL iss_wb_err got=%b exp=0", err); end
        rd_use_b = 1; rd_addr_b = 4'd9; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL iss_wb_stall got=%b exp=1", stall); end
        wb_en = 1; wb_addr = 4'd9; wb_data = 16'h0099; tick();
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL iss_wb_clear got=%0d exp=0", pend_count); end
    endtask

    task automatic test_double_issue();
        iss_en = 1; iss_addr = 4'd7; tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_issue_err got=%b exp=0", err); end
        iss_en = 1; iss_addr = 4'd7; tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL double_issue_err got=%b exp=1", err); end
        wa_en = 1; wa_addr = 4'd7; wa_data = 16'h0007; tick();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL double_pend got=%0d exp=0", pend_count); end
    endtask

    task automatic test_reset_mid();
        iss_en = 1; iss_addr = 4'd2; tick();
        iss_en = 1; iss_addr = 4'd4; tick();
        checks++; if (pend_count !== 5'd2) begin errors++; $display("FAIL pre_reset_pend got=%0d exp=2", pend_count); end
        rd_use_a = 1; rd_addr_a = 4'd2; rd_addr_b = 4'd15;
        wa_en = 1; wa_addr = 4'd3; wa_data = 16'hDEAD;
        iss_en = 1; iss_addr = 4'd10; #1;
        reset = 1; #1;
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL mid_reset_pend got=%0d exp=0", pend_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got=%b exp=0", stall); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got=%b exp=0", err); end
        checks++; if (rd_data_b !== 16'hFFFE) begin errors++; $display("FAIL mid_reset_sp got=%h exp=fffe", rd_data_b); end
        @(posedge clk); #1;
        reset = 0; idle(); rd_addr_a = 4'd3; rd_addr_b = 4'd5; #1;
        checks++; if (rd_data_a !== 16'h0000) begin errors++; $display("FAIL lost_write got=%h exp=0000", rd_data_a); end
        checks++; if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL reset_r5 got=%h exp=0000", rd_data_b); end
        checks++; if (pend_count !== 5'd0) begin errors++; $display("FAIL lost_issue got=%0d exp=0", pend_count); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero();
        test_result_reg();
        test_hazard();
        test_issue_wb_same();
        test_double_issue();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL have parameter RESULT_IDX, default 0, index driven on result_reg.
REQ-004 The block SHALL have parameter ZERO_IDX, default 1, hardwired-zero register index.
REQ-005 The block SHALL have parameter SP_IDX, default 15, stack-pointer register index.
REQ-006 The block SHALL have parameter SP_INIT, default 16'hFFFE, SP reset value.
REQ-007 The block SHALL have port clk, input, 1, clock; all state updates occur on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 The block SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_W, read source indices.
REQ-010 The block SHALL have ports rd_use_a and rd_use_b, input, 1, source actually consumed this cycle.
REQ-011 The block SHALL have ports rd_data_a and rd_data_b, output, DATA_W, read data.
REQ-012 The block SHALL have ports wa_en, wa_addr and wa_data, input, 1/ADDR_W/DATA_W, write port A.
REQ-013 The block SHALL have ports wb_en, wb_addr and wb_data, input, 1/ADDR_W/DATA_W, write port B.
REQ-014 The block SHALL have ports iss_en and iss_addr, input, 1/ADDR_W, issue marks destination pending.
REQ-015 The block SHALL have port stall, output, 1, read-after-write hazard on a used source.
REQ-016 The block SHALL have port pend_count, output, ADDR_W+1, number of pending registers.
REQ-017 The block SHALL have port err, output, 1, sticky double-issue error.
REQ-018 The block SHALL have port result_reg, output, DATA_W, current value of RESULT_IDX.

Function
REQ-019 Each write port SHALL update its target register at the clock edge when its enable is high.
REQ-020 Writes to ZERO_IDX SHALL be discarded, and reads of ZERO_IDX SHALL return 0 at all times.
REQ-021 When both write ports are enabled to the same address, port B data SHALL be stored.
REQ-022 Reads SHALL be combinational with same-cycle bypass: an enabled write to the read address SHALL return that write's data, with port B taking priority over port A.
REQ-023 result_reg SHALL follow the stored value of RESULT_IDX without bypass.
REQ-024 The pending bit of iss_addr SHALL be set at the edge when iss_en is high; issues to ZERO_IDX SHALL be ignored.
REQ-025 The pending bit of any enabled write address SHALL be cleared at the edge.
REQ-026 If issue and writeback target the same address in the same cycle, the pending bit SHALL remain set, because the new producer wins.
REQ-027 hazard_x SHALL be computed as rd_use_x AND pend[rd_addr_x] AND NOT (enabled write to rd_addr_x this cycle); stall SHALL be hazard_a OR hazard_b, combinationally.
REQ-028 err SHALL be set at the edge when iss_en targets an address already pending and not cleared that cycle, and SHALL hold until reset.
REQ-029 pend_count SHALL equal the popcount of the registered pending vector, ranging from 0 to NUM_REGS-1 (ZERO_IDX excluded).
REQ-030 All index inputs SHALL be full-range; no out-of-range case exists.

Reset
REQ-031 On reset, all registers SHALL be cleared to 0 except SP_IDX, which SHALL be set to SP_INIT.
REQ-032 On reset, all pending bits and err SHALL be cleared, so that stall=0, pend_count=0 and result_reg=0.
REQ-033 An assertion of reset mid-operation SHALL immediately clear state; writes or issues in that cycle SHALL be lost.

Verification
REQ-034 Reset -> read SP_IDX=16'hFFFE, rd_addr_a=3 returns 0, pend_count=0, err=0.
REQ-035 Write 16'h1234 to r3 via port A while reading r3 the same cycle -> rd_data=16'h1234 before the edge; after the edge the stored value is 16'h1234.
REQ-036 Same cycle, A writes 16'hAAAA to r5 and B writes 16'h5555 to r5 -> bypass and stored value both 16'h5555; write 16'hFFFF to ZERO_IDX -> reads stay 0.
REQ-037 Issue r7; next cycle rd_use_a=1 with rd_addr_a=7 -> stall=1 and pend_count=1; in the writeback cycle for r7 -> stall=0; afterwards pend_count=0.
REQ-038 Issue r7 twice without writeback -> err=1 and stays 1; issue plus writeback of r7 in the same cycle -> pend bit stays set and err is not set.
REQ-039 Issue r2 and r4, then assert reset mid-stream -> pend_count=0, stall=0, err=0 immediately.
